// File: rtl/assertion_ctrl_pkg.sv
// rtl/assertion_ctrl_pkg.sv - shared op codes, FSM states and defaults for assertion_ctrl_gen
package assertion_ctrl_pkg;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_ON   = 2'd1;
    localparam logic [1:0] OP_OFF  = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CLEAR = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    localparam int DEF_DEPTH          = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/assertion_ctrl_gen_if.sv
// rtl/assertion_ctrl_gen_if.sv - command/completion interface of assertion_ctrl_gen
interface assertion_ctrl_gen_if;

    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic       done_valid;
    logic [1:0] done_op;
    logic       done_err;

    modport master (
        output cmd_valid, cmd_op,
        input  cmd_ready, done_valid, done_op, done_err
    );

    modport slave (
        input  cmd_valid, cmd_op,
        output cmd_ready, done_valid, done_op, done_err
    );

endinterface

// File: rtl/assertion_ctrl_fifo.sv
// rtl/assertion_ctrl_fifo.sv - synchronous command FIFO with registered full/empty flags
import assertion_ctrl_pkg::*;

module assertion_ctrl_fifo #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = 2
) (
    input  logic             fclk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic             empty_nxt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge fclk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q[AW-1:0]];
    assign full      = full_q;
    assign empty     = empty_q;
    assign empty_nxt = empty_d;

endmodule

// File: rtl/assertion_ctrl_gen.sv
// rtl/assertion_ctrl_gen.sv - queued $asserton/$assertoff level generator; ASSERT_CTRL_TIMEOUT_EN adds an event_on wait timeout
import assertion_ctrl_pkg::*;

module assertion_ctrl_gen #(
    parameter int DEPTH          = DEF_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                fclk,
    input  logic                rst,
    input  logic                event_on,
    assertion_ctrl_gen_if.slave cmd_if,
    output logic                assertion_global_on_s,
    output logic                assertion_global_off_s,
    output logic                assert_enabled,
    output logic                busy
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_DRIVE = ST_DRIVE;
    localparam logic [1:0] S_CLEAR = ST_CLEAR;
    localparam logic [1:0] S_ACK   = ST_ACK;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("assertion_ctrl_gen: TIMEOUT_CYCLES must be >= 2");
    end

    logic [1:0] state_q, state_d;
    logic       on_q, on_d, off_q, off_d;
    logic [1:0] op_q, op_d;
    logic       err_q, err_d;
    logic       done_valid_q, done_valid_d;
    logic [1:0] done_op_q, done_op_d;
    logic       done_err_q, done_err_d;
    logic       en_q, en_d;
    logic       busy_q, busy_d;

    logic       fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_empty_nxt;
    logic [1:0] fifo_head;

`ifdef ASSERT_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer_q, timer_d;
`endif

    // cmd_ready comes from the registered full flag, so a same-cycle pop never frees a slot early.
    assign fifo_push = cmd_if.cmd_valid & ~fifo_full;

    assertion_ctrl_fifo #(.DEPTH(DEPTH), .WIDTH(2)) u_fifo (
        .fclk      (fclk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (cmd_if.cmd_op),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .empty_nxt (fifo_empty_nxt)
    );

    always_comb begin
        state_d      = state_q;
        on_d         = on_q;
        off_d        = off_q;
        op_d         = op_q;
        err_d        = err_q;
        done_valid_d = 1'b0;
        done_op_d    = done_op_q;
        done_err_d   = done_err_q;
        en_d         = en_q;
        fifo_pop     = 1'b0;
`ifdef ASSERT_CTRL_TIMEOUT_EN
        timer_d      = timer_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef ASSERT_CTRL_TIMEOUT_EN
                timer_d = '0;
`endif
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = fifo_head;
                    err_d    = (fifo_head == OP_RSVD);
                    if (fifo_head == OP_ON) begin
                        on_d    = 1'b1;
                        state_d = S_DRIVE;
                    end else if (fifo_head == OP_OFF) begin
                        off_d   = 1'b1;
                        state_d = S_DRIVE;
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_DRIVE: begin
                if (event_on) begin
                    on_d    = 1'b0;
                    off_d   = 1'b0;
                    state_d = S_CLEAR;
`ifdef ASSERT_CTRL_TIMEOUT_EN
                    timer_d = '0;
                end else if (timer_q == TIMER_MAX) begin
                    on_d    = 1'b0;
                    off_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
            end
            S_CLEAR: begin
                if (event_on) begin
                    state_d = S_ACK;
`ifdef ASSERT_CTRL_TIMEOUT_EN
                end else if (timer_q == TIMER_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
            end
            default: begin
                done_valid_d = 1'b1;
                done_op_d    = op_q;
                done_err_d   = err_q;
                if (!err_q && op_q == OP_ON)  en_d = 1'b1;
                if (!err_q && op_q == OP_OFF) en_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE) | ~fifo_empty_nxt;
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            on_q         <= 1'b0;
            off_q        <= 1'b0;
            op_q         <= OP_NOP;
            err_q        <= 1'b0;
            done_valid_q <= 1'b0;
            done_op_q    <= OP_NOP;
            done_err_q   <= 1'b0;
            en_q         <= 1'b1;
            busy_q       <= 1'b0;
`ifdef ASSERT_CTRL_TIMEOUT_EN
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            on_q         <= on_d;
            off_q        <= off_d;
            op_q         <= op_d;
            err_q        <= err_d;
            done_valid_q <= done_valid_d;
            done_op_q    <= done_op_d;
            done_err_q   <= done_err_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
`ifdef ASSERT_CTRL_TIMEOUT_EN
            timer_q      <= timer_d;
`endif
        end
    end

    assign cmd_if.cmd_ready     = ~fifo_full;
    assign cmd_if.done_valid    = done_valid_q;
    assign cmd_if.done_op       = done_op_q;
    assign cmd_if.done_err      = done_err_q;
    assign assertion_global_on_s  = on_q;
    assign assertion_global_off_s = off_q;
    assign assert_enabled         = en_q;
    assign busy                   = busy_q;

endmodule
